// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing one registered CDB between ALU and LSB result FIFOs
// Each source queues results in a small FIFO; one head per cycle is granted onto the bus.
module cdb_arbiter #(
  parameter int ROB_ID_W   = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                rollback_signal,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_alias,
  input  logic [DATA_W-1:0]   alu_value,
  input  logic                alu_jump_res,
  input  logic [DATA_W-1:0]   alu_jump_pc,
  output logic                alu_ready,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_alias,
  input  logic [DATA_W-1:0]   lsb_value,
  output logic                lsb_ready,
  output logic                cdb_valid,
  output logic                cdb_src,
  output logic [ROB_ID_W-1:0] cdb_alias,
  output logic [DATA_W-1:0]   cdb_value,
  output logic                cdb_jump_res,
  output logic [DATA_W-1:0]   cdb_jump_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = ROB_ID_W + DATA_W + 1 + DATA_W;
  localparam int LW = ROB_ID_W + DATA_W;

  logic [AW-1:0] alu_mem_q [FIFO_DEPTH];
  logic [LW-1:0] lsb_mem_q [FIFO_DEPTH];

  logic [CW-1:0] alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  logic [PW-1:0] alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [PW-1:0] lsb_wr_q, lsb_wr_d, lsb_rd_q, lsb_rd_d;
  logic          rr_last_q, rr_last_d;

  logic                cdb_valid_q, cdb_valid_d;
  logic                cdb_src_q, cdb_src_d;
  logic [ROB_ID_W-1:0] cdb_alias_q, cdb_alias_d;
  logic [DATA_W-1:0]   cdb_value_q, cdb_value_d;
  logic                cdb_jump_res_q, cdb_jump_res_d;
  logic [DATA_W-1:0]   cdb_jump_pc_q, cdb_jump_pc_d;

  logic          alu_push, lsb_push, alu_pop, lsb_pop;
  logic          alu_ne, lsb_ne, grant_alu, grant_lsb, run;
  logic [AW-1:0] alu_head;
  logic [LW-1:0] lsb_head;

  assign run       = rdy & ~rollback_signal;
  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign alu_ready = run & (alu_cnt_q < CW'(FIFO_DEPTH));
  assign lsb_ready = run & (lsb_cnt_q < CW'(FIFO_DEPTH));
  assign alu_push  = alu_valid & alu_ready;
  assign lsb_push  = lsb_valid & lsb_ready;

  assign alu_ne    = alu_cnt_q != '0;
  assign lsb_ne    = lsb_cnt_q != '0;
  // rr_last_q = 1 means LSB won last, so ALU takes the next contention.
  assign grant_alu = alu_ne & (~lsb_ne | rr_last_q);
  assign grant_lsb = lsb_ne & (~alu_ne | ~rr_last_q);
  assign alu_pop   = run & grant_alu;
  assign lsb_pop   = run & grant_lsb;
  assign alu_head  = alu_mem_q[alu_rd_q];
  assign lsb_head  = lsb_mem_q[lsb_rd_q];

  always_comb begin
    alu_cnt_d      = alu_cnt_q;
    lsb_cnt_d      = lsb_cnt_q;
    alu_wr_d       = alu_wr_q;
    alu_rd_d       = alu_rd_q;
    lsb_wr_d       = lsb_wr_q;
    lsb_rd_d       = lsb_rd_q;
    rr_last_d      = rr_last_q;
    cdb_valid_d    = cdb_valid_q;
    cdb_src_d      = cdb_src_q;
    cdb_alias_d    = cdb_alias_q;
    cdb_value_d    = cdb_value_q;
    cdb_jump_res_d = cdb_jump_res_q;
    cdb_jump_pc_d  = cdb_jump_pc_q;
    if (rollback_signal) begin
      alu_cnt_d   = '0;
      lsb_cnt_d   = '0;
      alu_wr_d    = '0;
      alu_rd_d    = '0;
      lsb_wr_d    = '0;
      lsb_rd_d    = '0;
      cdb_valid_d = 1'b0;
    end else if (rdy) begin
      alu_wr_d    = alu_wr_q + PW'(alu_push);
      alu_rd_d    = alu_rd_q + PW'(alu_pop);
      lsb_wr_d    = lsb_wr_q + PW'(lsb_push);
      lsb_rd_d    = lsb_rd_q + PW'(lsb_pop);
      alu_cnt_d   = alu_cnt_q + CW'(alu_push) - CW'(alu_pop);
      lsb_cnt_d   = lsb_cnt_q + CW'(lsb_push) - CW'(lsb_pop);
      cdb_valid_d = alu_pop | lsb_pop;
      if (alu_pop) begin
        rr_last_d = 1'b0;
        cdb_src_d = 1'b0;
        {cdb_alias_d, cdb_value_d, cdb_jump_res_d, cdb_jump_pc_d} = alu_head;
      end else if (lsb_pop) begin
        rr_last_d      = 1'b1;
        cdb_src_d      = 1'b1;
        {cdb_alias_d, cdb_value_d} = lsb_head;
        cdb_jump_res_d = 1'b0;
        cdb_jump_pc_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alu_push) alu_mem_q[alu_wr_q] <= {alu_alias, alu_value, alu_jump_res, alu_jump_pc};
    if (lsb_push) lsb_mem_q[lsb_wr_q] <= {lsb_alias, lsb_value};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cnt_q      <= '0;
      lsb_cnt_q      <= '0;
      alu_wr_q       <= '0;
      alu_rd_q       <= '0;
      lsb_wr_q       <= '0;
      lsb_rd_q       <= '0;
      rr_last_q      <= 1'b1;
      cdb_valid_q    <= 1'b0;
      cdb_src_q      <= 1'b0;
      cdb_alias_q    <= '0;
      cdb_value_q    <= '0;
      cdb_jump_res_q <= 1'b0;
      cdb_jump_pc_q  <= '0;
    end else begin
      alu_cnt_q      <= alu_cnt_d;
      lsb_cnt_q      <= lsb_cnt_d;
      alu_wr_q       <= alu_wr_d;
      alu_rd_q       <= alu_rd_d;
      lsb_wr_q       <= lsb_wr_d;
      lsb_rd_q       <= lsb_rd_d;
      rr_last_q      <= rr_last_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_src_q      <= cdb_src_d;
      cdb_alias_q    <= cdb_alias_d;
      cdb_value_q    <= cdb_value_d;
      cdb_jump_res_q <= cdb_jump_res_d;
      cdb_jump_pc_q  <= cdb_jump_pc_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_src      = cdb_src_q;
  assign cdb_alias    = cdb_alias_q;
  assign cdb_value    = cdb_value_q;
  assign cdb_jump_res = cdb_jump_res_q;
  assign cdb_jump_pc  = cdb_jump_pc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
// Directed vector table, hand sequences, and randomized traffic against a queue-based model.
module tb_cdb_arbiter;
  localparam int RW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 2;
  localparam int NV = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rdy, rollback_signal;
  logic          alu_valid, alu_jump_res, alu_ready;
  logic [RW-1:0] alu_alias;
  logic [DW-1:0] alu_value, alu_jump_pc;
  logic          lsb_valid, lsb_ready;
  logic [RW-1:0] lsb_alias;
  logic [DW-1:0] lsb_value;
  logic          cdb_valid, cdb_src, cdb_jump_res;
  logic [RW-1:0] cdb_alias;
  logic [DW-1:0] cdb_value, cdb_jump_pc;

  cdb_arbiter #(.ROB_ID_W(RW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback_signal(rollback_signal),
    .alu_valid(alu_valid), .alu_alias(alu_alias), .alu_value(alu_value),
    .alu_jump_res(alu_jump_res), .alu_jump_pc(alu_jump_pc), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_alias(lsb_alias), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_alias(cdb_alias), .cdb_value(cdb_value),
    .cdb_jump_res(cdb_jump_res), .cdb_jump_pc(cdb_jump_pc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic av; logic [RW-1:0] aa; logic [DW-1:0] avl; logic ajr; logic [DW-1:0] apc;
    logic lv; logic [RW-1:0] la; logic [DW-1:0] lvl;
    logic rdy; logic rb;
    logic e_ar; logic e_lr;
    logic e_cv; logic e_src; logic [RW-1:0] e_a; logic [DW-1:0] e_v; logic e_jr; logic [DW-1:0] e_pc;
  } vec_t;

  function automatic vec_t mk(
      input logic av, input logic [RW-1:0] aa, input logic [DW-1:0] avl, input logic ajr,
      input logic [DW-1:0] apc, input logic lv, input logic [RW-1:0] la, input logic [DW-1:0] lvl,
      input logic r, input logic rb, input logic ear, input logic elr, input logic ecv,
      input logic esrc, input logic [RW-1:0] ea, input logic [DW-1:0] ev, input logic ejr,
      input logic [DW-1:0] epc);
    vec_t v;
    v.av = av; v.aa = aa; v.avl = avl; v.ajr = ajr; v.apc = apc;
    v.lv = lv; v.la = la; v.lvl = lvl; v.rdy = r; v.rb = rb;
    v.e_ar = ear; v.e_lr = elr; v.e_cv = ecv; v.e_src = esrc;
    v.e_a = ea; v.e_v = ev; v.e_jr = ejr; v.e_pc = epc;
    return v;
  endfunction

  // Reference model: per-source queues plus the last-winner bit and the broadcast register.
  typedef struct { logic [RW-1:0] a; logic [DW-1:0] v; logic jr; logic [DW-1:0] pc; } res_t;
  res_t aq[$];
  res_t lq[$];
  logic          m_rr, m_cv, m_src, m_jr;
  logic [RW-1:0] m_alias;
  logic [DW-1:0] m_val, m_pc;

  function automatic logic m_ar();
    return rdy && !rollback_signal && (aq.size() < DEPTH);
  endfunction
  function automatic logic m_lr();
    return rdy && !rollback_signal && (lq.size() < DEPTH);
  endfunction

  task automatic model_reset();
    aq.delete(); lq.delete();
    m_rr = 1'b1; m_cv = 1'b0; m_src = 1'b0; m_jr = 1'b0;
    m_alias = '0; m_val = '0; m_pc = '0;
  endtask

  task automatic model_edge();
    logic ar, lr;
    res_t r;
    ar = m_ar();
    lr = m_lr();
    if (rollback_signal) begin
      aq.delete(); lq.delete();
      m_cv = 1'b0;
    end else if (rdy) begin
      if (aq.size() > 0 && (lq.size() == 0 || m_rr)) begin
        r = aq.pop_front();
        m_cv = 1'b1; m_src = 1'b0; m_alias = r.a; m_val = r.v; m_jr = r.jr; m_pc = r.pc; m_rr = 1'b0;
      end else if (lq.size() > 0) begin
        r = lq.pop_front();
        m_cv = 1'b1; m_src = 1'b1; m_alias = r.a; m_val = r.v; m_jr = 1'b0; m_pc = '0; m_rr = 1'b1;
      end else begin
        m_cv = 1'b0;
      end
      if (alu_valid && ar) aq.push_back('{alu_alias, alu_value, alu_jump_res, alu_jump_pc});
      if (lsb_valid && lr) lq.push_back('{lsb_alias, lsb_value, 1'b0, '0});
    end
  endtask

  // Inputs must already be set; checks ready before the edge and the CDB after it.
  task automatic model_cycle(input string tag);
    #1;
    chk({tag, "_alu_ready"}, alu_ready, m_ar());
    chk({tag, "_lsb_ready"}, lsb_ready, m_lr());
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_cdb_valid"}, cdb_valid, m_cv);
    chk({tag, "_cdb_src"}, cdb_src, m_src);
    chk({tag, "_cdb_alias"}, cdb_alias, m_alias);
    chk({tag, "_cdb_value"}, cdb_value, m_val);
    chk({tag, "_cdb_jump_res"}, cdb_jump_res, m_jr);
    chk({tag, "_cdb_jump_pc"}, cdb_jump_pc, m_pc);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; lsb_valid = 1'b0; rollback_signal = 1'b0; rdy = 1'b1;
    alu_alias = '0; alu_value = '0; alu_jump_res = 1'b0; alu_jump_pc = '0;
    lsb_alias = '0; lsb_value = '0;
  endtask

  task automatic reset_all();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_cdb_alias", cdb_alias, '0);
    chk("rst_cdb_value", cdb_value, '0);
    chk("rst_cdb_jump_pc", cdb_jump_pc, '0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_lsb_ready", lsb_ready, 1'b1);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vt[NV];

  initial begin
    vt[0]  = mk(1, 3, 32'h55, 1, 32'h1000, 0, 0, 0,    1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0,             0, 0, 0,    1, 0, 1, 1, 1, 0, 3, 32'h55, 1, 32'h1000);
    vt[2]  = mk(0, 0, 0, 0, 0,             0, 0, 0,    1, 0, 1, 1, 0, 0, 3, 32'h55, 1, 32'h1000);
    vt[3]  = mk(0, 0, 0, 0, 0,             1, 7, 32'h70, 1, 0, 1, 1, 0, 0, 3, 32'h55, 1, 32'h1000);
    vt[4]  = mk(1, 4, 32'h44, 0, 32'h2000, 1, 8, 32'h80, 1, 0, 1, 1, 1, 1, 7, 32'h70, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0,             1, 9, 32'h90, 1, 0, 1, 1, 1, 0, 4, 32'h44, 0, 32'h2000);
    vt[6]  = mk(0, 0, 0, 0, 0,             0, 0, 0,    0, 0, 0, 0, 1, 0, 4, 32'h44, 0, 32'h2000);
    vt[7]  = mk(0, 0, 0, 0, 0,             0, 0, 0,    0, 0, 0, 0, 1, 0, 4, 32'h44, 0, 32'h2000);
    vt[8]  = mk(0, 0, 0, 0, 0,             0, 0, 0,    1, 0, 1, 0, 1, 1, 8, 32'h80, 0, 0);
    vt[9]  = mk(0, 0, 0, 0, 0,             0, 0, 0,    1, 0, 1, 1, 1, 1, 9, 32'h90, 0, 0);
    vt[10] = mk(0, 0, 0, 0, 0,             0, 0, 0,    1, 0, 1, 1, 0, 1, 9, 32'h90, 0, 0);
    vt[11] = mk(1, 1, 32'h11, 1, 32'h3000, 1, 2, 32'h22, 1, 0, 1, 1, 0, 1, 9, 32'h90, 0, 0);
    vt[12] = mk(1, 3, 32'h33, 0, 32'h3300, 1, 4, 32'h44, 1, 0, 1, 1, 1, 0, 1, 32'h11, 1, 32'h3000);
    vt[13] = mk(1, 5, 32'h55, 1, 32'h3500, 0, 0, 0,    1, 0, 1, 0, 1, 1, 2, 32'h22, 0, 0);
    vt[14] = mk(0, 0, 0, 0, 0,             0, 0, 0,    0, 1, 0, 0, 0, 1, 2, 32'h22, 0, 0);
    vt[15] = mk(0, 0, 0, 0, 0,             0, 0, 0,    1, 0, 1, 1, 0, 1, 2, 32'h22, 0, 0);
    vt[16] = mk(1, 6, 32'h66, 0, 0,        1, 7, 32'h77, 1, 0, 1, 1, 0, 1, 2, 32'h22, 0, 0);
    vt[17] = mk(0, 0, 0, 0, 0,             0, 0, 0,    1, 0, 1, 1, 1, 0, 6, 32'h66, 0, 0);
    vt[18] = mk(0, 0, 0, 0, 0,             0, 0, 0,    1, 0, 1, 1, 1, 1, 7, 32'h77, 0, 0);
    vt[19] = mk(0, 0, 0, 0, 0,             0, 0, 0,    1, 0, 1, 1, 0, 1, 7, 32'h77, 0, 0);

    reset_all();

    for (int i = 0; i < NV; i++) begin
      alu_valid = vt[i].av; alu_alias = vt[i].aa; alu_value = vt[i].avl;
      alu_jump_res = vt[i].ajr; alu_jump_pc = vt[i].apc;
      lsb_valid = vt[i].lv; lsb_alias = vt[i].la; lsb_value = vt[i].lvl;
      rdy = vt[i].rdy; rollback_signal = vt[i].rb;
      #1;
      chk($sformatf("v%0d_alu_ready", i), alu_ready, vt[i].e_ar);
      chk($sformatf("v%0d_lsb_ready", i), lsb_ready, vt[i].e_lr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cdb_valid", i), cdb_valid, vt[i].e_cv);
      chk($sformatf("v%0d_cdb_src", i), cdb_src, vt[i].e_src);
      chk($sformatf("v%0d_cdb_alias", i), cdb_alias, vt[i].e_a);
      chk($sformatf("v%0d_cdb_value", i), cdb_value, vt[i].e_v);
      chk($sformatf("v%0d_cdb_jump_res", i), cdb_jump_res, vt[i].e_jr);
      chk($sformatf("v%0d_cdb_jump_pc", i), cdb_jump_pc, vt[i].e_pc);
    end

    // Sustained two-source burst; producers respect ready, queues check order and alternation.
    reset_all();
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      alu_valid = m_ar(); alu_alias = RW'(i + 1); alu_value = 32'hA000 + i;
      alu_jump_res = i[0]; alu_jump_pc = 32'h4000 + 4 * i;
      lsb_valid = m_lr(); lsb_alias = RW'(i + 9); lsb_value = 32'hB000 + i;
      model_cycle($sformatf("burst%0d", i));
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) model_cycle($sformatf("drain%0d", i));
    chk("burst_alu_empty", aq.size(), 0);
    chk("burst_lsb_empty", lq.size(), 0);

    // Asynchronous reset landing between edges while a result is on the bus.
    idle_inputs();
    alu_valid = 1'b1; alu_alias = 4'hA; alu_value = 32'hAA;
    lsb_valid = 1'b1; lsb_alias = 4'hB; lsb_value = 32'hBB;
    model_cycle("ar_fill");
    idle_inputs();
    model_cycle("ar_busy");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cdb_valid", cdb_valid, 1'b0);
    chk("async_rst_cdb_alias", cdb_alias, '0);
    chk("async_rst_alu_ready", alu_ready, 1'b1);
    chk("async_rst_lsb_ready", lsb_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    alu_valid = 1'b1; alu_alias = 4'h2; alu_value = 32'h22;
    lsb_valid = 1'b1; lsb_alias = 4'h3; lsb_value = 32'h33;
    model_cycle("post_rst_push");
    idle_inputs();
    model_cycle("post_rst_grant");
    chk("post_rst_alu_first", cdb_src, 1'b0);
    chk("post_rst_alias", cdb_alias, 4'h2);
    model_cycle("post_rst_second");

    // Randomized traffic with pauses and rollbacks.
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      rdy = ($urandom_range(0, 7) != 0);
      rollback_signal = ($urandom_range(0, 24) == 0);
      alu_valid = m_ar() && ($urandom_range(0, 2) != 0);
      alu_alias = RW'($urandom); alu_value = $urandom;
      alu_jump_res = RW'($urandom) != 0; alu_jump_pc = $urandom;
      lsb_valid = m_lr() && ($urandom_range(0, 2) != 0);
      lsb_alias = RW'($urandom); lsb_value = $urandom;
      model_cycle($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
